// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises rx_in, qualifies the start bit, samples each
// bit at mid-period on the 16x clock, checks parity and stop, and emits one-cycle pulses.
module uart_rx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Bclkx16_,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_valid,
  output logic                 strt_sig,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  localparam logic       PAR_ODD  = 1'(PARITY_ODD);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_e               state, state_n;
  logic                 sync1, rx_s;
  logic [3:0]           tick, tick_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic                 par_acc, par_acc_n;
  logic                 par_err, par_err_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 data_valid_n, strt_sig_n, err_n;

  always_comb begin
    // NOTE: every next-value is defaulted before the case so no path leaves one unassigned (no latches).
    state_n      = state;
    tick_n       = tick + 4'd1;
    bit_cnt_n    = bit_cnt;
    par_acc_n    = par_acc;
    par_err_n    = par_err;
    shreg_n      = shreg;
    rx_data_n    = rx_data;
    data_valid_n = 1'b0;
    strt_sig_n   = 1'b0;
    err_n        = 1'b0;

    unique case (state)
      S_IDLE: begin
        tick_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        // Any return to high before the centre is treated as a glitch.
        if (rx_s) begin
          state_n = S_IDLE;
        end else if (tick == 4'd7) begin
          strt_sig_n = 1'b1;
          tick_n     = '0;
          bit_cnt_n  = '0;
          par_acc_n  = 1'b0;
          par_err_n  = 1'b0;
          state_n    = S_DATA;
        end
      end
      S_DATA: begin
        if (tick == 4'd15) begin
          shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
          par_acc_n = par_acc ^ rx_s;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick == 4'd15) begin
          par_err_n = par_acc ^ rx_s ^ PAR_ODD;
          state_n   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick == 4'd15) begin
          rx_data_n = shreg;
          if (!rx_s) begin
            err_n   = 1'b1;
            state_n = S_BREAK;
          end else if (par_err) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            data_valid_n = 1'b1;
            state_n      = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must return high before another start is accepted.
        tick_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Bclkx16_) begin
    // NOTE: registered state is written with non-blocking assignments so all flops update together.
    if (!rst) begin
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      par_err    <= 1'b0;
      shreg      <= '0;
      rx_data    <= '0;
      data_valid <= 1'b0;
      strt_sig   <= 1'b0;
      err        <= 1'b0;
    end else begin
      sync1      <= rx_in;
      rx_s       <= sync1;
      state      <= state_n;
      tick       <= tick_n;
      bit_cnt    <= bit_cnt_n;
      par_acc    <= par_acc_n;
      par_err    <= par_err_n;
      shreg      <= shreg_n;
      rx_data    <= rx_data_n;
      data_valid <= data_valid_n;
      strt_sig   <= strt_sig_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: table of directed frames, hand-written corner sequences,
// and random frames checked against a frame-level event model (expected pulse cycles and data).
module tb_uart_rx_framer;

  localparam int D   = 8;
  localparam int P   = 1;
  localparam int ODD = 0;
  localparam int BIT = 16;

  typedef enum int {EV_START, EV_VALID, EV_ERR} ev_kind_e;
  typedef struct {
    int       cyc;
    ev_kind_e kind;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       stop;
    int         low_hold;
    logic       exp_valid;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       data_valid, strt_sig, err;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];
  ev_t act_q[$];
  int  valid_cyc[$];
  ev_t mon_ev;

  uart_rx_framer #(.DATA_BITS(D), .PARITY_EN(P), .PARITY_ODD(ODD)) dut (
    .Bclkx16_  (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .data_valid(data_valid),
    .strt_sig  (strt_sig),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (strt_sig === 1'b1 || data_valid === 1'b1 || err === 1'b1)
      check("pulse_exclusive", int'((data_valid & err) | (strt_sig & (data_valid | err))), 0);
    if (strt_sig === 1'b1) begin
      mon_ev.cyc = cyc; mon_ev.kind = EV_START; mon_ev.data = 8'h00;
      act_q.push_back(mon_ev);
    end
    if (data_valid === 1'b1) begin
      mon_ev.cyc = cyc; mon_ev.kind = EV_VALID; mon_ev.data = rx_data;
      act_q.push_back(mon_ev);
    end
    if (err === 1'b1) begin
      mon_ev.cyc = cyc; mon_ev.kind = EV_ERR; mon_ev.data = rx_data;
      act_q.push_back(mon_ev);
    end
  end

  // Frame-level model: line goes low at cycle n; rx_s lags by 3 edges, the start
  // centre is 8 edges later, and each following bit centre is one bit period on.
  task automatic model_start(input int n);
    ev_t e;
    e.cyc = n + 3 + 8; e.kind = EV_START; e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic model_end(input int n, input logic [7:0] d, input logic pbit, input logic stop);
    ev_t  e;
    logic perr;
    perr   = (P != 0) && (((^d) ^ pbit ^ 1'(ODD)) != 1'b0);
    e.cyc  = n + 3 + 8 + BIT * (D + 1 + P);
    e.kind = (stop && !perr) ? EV_VALID : EV_ERR;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                            input int low_hold, input int gap);
    logic pbit;
    int   n;
    pbit = (^d) ^ 1'(ODD) ^ flip;
    n    = cyc;
    model_start(n);
    model_end(n, d, pbit, stop);
    drive_bit(1'b0);
    for (int i = 0; i < D; i++) drive_bit(d[i]);
    if (P != 0) drive_bit(pbit);
    drive_bit(stop);
    if (low_hold > 0) begin
      rx_in = 1'b0;
      repeat (low_hold) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_events(output int nv, output int ne, output int nt);
    ev_t a, e;
    nv = 0; ne = 0; nt = 0;
    while (exp_q.size() > 0 || act_q.size() > 0) begin
      if (act_q.size() == 0) begin
        e = exp_q.pop_front();
        check("event_missing_at_cycle", -1, e.cyc);
      end else begin
        a = act_q.pop_front();
        nt++;
        if (a.kind == EV_VALID) begin nv++; valid_cyc.push_back(a.cyc); end
        if (a.kind == EV_ERR) ne++;
        if (exp_q.size() == 0) begin
          check("unexpected_event_cycle", a.cyc, -1);
        end else begin
          e = exp_q.pop_front();
          check("ev_cycle", a.cyc, e.cyc);
          check("ev_kind", int'(a.kind), int'(e.kind));
          check("ev_data", int'(a.data), int'(e.data));
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data_valid"}, int'(data_valid), 0);
    check({tag, "_strt_sig"},   int'(strt_sig),   0);
    check({tag, "_err"},        int'(err),        0);
    check({tag, "_rx_data"},    int'(rx_data),    0);
  endtask

  initial begin
    vec_t vecs[7];
    int   nv, ne, nt, n;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0,  1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 0,  1'b0, 1'b1};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 40, 1'b0, 1'b1};
    vecs[3] = '{8'h12, 1'b0, 1'b1, 0,  1'b1, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 0,  1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 0,  1'b1, 1'b0};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, 5,  1'b0, 1'b1};

    rst   = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].flip, vecs[i].stop, vecs[i].low_hold, 24);
      check_events(nv, ne, nt);
      check($sformatf("tbl%0d_valid_count", i), nv, int'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_err_count", i), ne, int'(vecs[i].exp_err));
      check($sformatf("tbl%0d_rx_data", i), int'(rx_data), int'(vecs[i].data));
    end

    // Glitch shorter than half a bit must leave the receiver idle.
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check_events(nv, ne, nt);
    check("glitch_event_count", nt, 0);
    send_frame(8'h3A, 1'b0, 1'b1, 0, 24);
    check_events(nv, ne, nt);
    check("after_glitch_valid", nv, 1);

    // Back-to-back frames with no idle time between them.
    valid_cyc.delete();
    send_frame(8'h00, 1'b0, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0, 24);
    check_events(nv, ne, nt);
    check("b2b_valid_count", valid_cyc.size(), 2);
    if (valid_cyc.size() == 2) check("b2b_spacing", valid_cyc[1] - valid_cyc[0], 176);

    // Reset in the middle of data bit 3 abandons the frame silently.
    send_frame(8'h5A, 1'b0, 1'b1, 0, 10);
    check_events(nv, ne, nt);
    d = 8'h96;
    n = cyc;
    model_start(n);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx_in = d[3];
    repeat (BIT / 2) @(negedge clk);
    rst   = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_events(nv, ne, nt);
    check("midreset_end_pulses", nv + ne, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 0, 24);
    check_events(nv, ne, nt);
    check("after_reset_valid", nv, 1);
    check("after_reset_rx_data", int'(rx_data), 8'hC3);

    // Random frames, gaps and error injection against the model.
    for (int i = 0; i < 25; i++) begin
      logic       flip, stop;
      int         gap;
      d    = 8'($urandom_range(255, 0));
      flip = ($urandom_range(3, 0) == 0);
      stop = ($urandom_range(4, 0) != 0);
      gap  = stop ? int'($urandom_range(30, 0)) : int'($urandom_range(30, 4));
      send_frame(d, flip, stop, 0, gap);
    end
    repeat (24) @(negedge clk);
    check_events(nv, ne, nt);
    check("random_total_end_pulses", nv + ne, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Serial-to-parallel front end of the UART receive path. It synchronises the raw serial input, detects and qualifies start bits, samples each bit at mid-period on the 16x baud clock, checks parity and stop bit, and delivers the received word. It feeds the downstream delay stage through its one-cycle `strt_sig` and `err` pulses, and delivers the received word on `rx_data` / `data_valid`.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8, LSB first on the line.
- `PARITY_EN`, default 1: 1 means a parity bit follows the data; 0 means no parity bit.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN=0`.
- `Bclkx16_` input, 1 bit: 16x baud clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-low reset; clock `Bclkx16_`.
- `rx_in` input, 1 bit: asynchronous serial line, idle high.
- `rx_data` output, `DATA_BITS` bits: last received word; updated at the end of every frame.
- `data_valid` output, 1 bit: one-cycle pulse for a good frame.
- `strt_sig` output, 1 bit: one-cycle pulse on a qualified start bit.
- `err` output, 1 bit: one-cycle pulse for a parity or framing error.

## Operation
- **Input synchroniser.** `rx_in` passes through 2 flops to give `rx_s`. The synchroniser flops reset to 1.
- **Counters.** `tick` is a 4-bit counter that wraps 15→0. `bit_cnt` is a 4-bit counter. `shreg` is a `DATA_BITS`-wide right-shift register; new bits enter at the MSB.
- **Running parity.** `par_acc` XORs the sampled data bits. A parity error is flagged when `par_acc ^ parity_bit ^ PARITY_ODD` is not 0.
- **IDLE state.**
  - If `rx_s==0`: go to START and set `tick` to 0.
- **START state.**
  - `tick` increments every cycle.
  - If `rx_s==1` at any edge: abort to IDLE with no output (glitch filter).
  - At the edge where `tick==7` and `rx_s==0`: this is the start-bit centre. Pulse `strt_sig`, clear `tick`, `bit_cnt` and `par_acc`, then go to DATA.
- **DATA state.**
  - At each edge where `tick==15`: shift `rx_s` into `shreg`, fold it into `par_acc`, and increment `bit_cnt`.
  - After the sample with `bit_cnt==DATA_BITS-1`: go to PARITY if `PARITY_EN=1`, else go to STOP.
- **PARITY state.**
  - At `tick==15`: sample `rx_s` as the parity bit and latch the parity error flag. Go to STOP.
- **STOP state.**
  - At `tick==15`: sample `rx_s` as the stop bit and load `rx_data <= shreg` (good or bad frame).
  - Stop bit 1 and no parity error: pulse `data_valid` and go to IDLE.
  - Parity error with stop bit 1: pulse `err` and go to IDLE.
  - Stop bit 0 (framing error, regardless of parity): pulse `err` and go to BREAK.
- **BREAK state.**
  - Hold until `rx_s==1`, then go to IDLE.
  - No new start is recognised while the line stays low.
- **Output exclusivity.** `data_valid` and `err` are never high in the same cycle. `strt_sig` is never high together with either of them.
- **Reset values** (synchronous, `rst==0` at an edge):
  - state = IDLE
  - `rx_data` = 0
  - `data_valid` = 0, `strt_sig` = 0, `err` = 0
  - `tick`, `bit_cnt`, `par_acc`, `shreg` = 0
- **Reset mid-frame.** Reset abandons the frame with no pulse. The next frame is accepted only after a fresh high-to-low transition is seen from IDLE.

## Timing
- **Edge E0.** E0 is the first edge at which IDLE sees `rx_s==0`. This is 2–3 edges after the `rx_in` fall because of the synchroniser.
- **Start qualification.** `strt_sig` is registered at edge E0+8 and is high for the following cycle.
- **Data bit sampling.** Data bit k (k=0..`DATA_BITS`-1) is sampled at edge E0+8+16(k+1).
- **Parity bit sampling.** When enabled, the parity bit is sampled at edge E0+8+16(`DATA_BITS`+1).
- **Stop bit sampling.** The stop bit is sampled at edge E0+8+16(`DATA_BITS`+1+`PARITY_EN`).
- **End-of-frame outputs.** `data_valid`/`err` and the new `rx_data` are registered at that same stop-sample edge, with no extra latency.
- **Back-to-back frames.** The next frame may start one bit-half after the stop centre. IDLE is re-entered on the cycle after the stop sample, so a start edge arriving 8 or more cycles later is detected.
- **Pulse width.** All pulses are exactly 1 cycle wide. There is no handshake; the consumer must sample every cycle.

## Test plan
- **Good frame.** Send 0xA5 with even parity (parity bit 0) and stop 1, at 16 clocks/bit (default parameters). Require `strt_sig` at E0+8, then `data_valid` = 1 for one cycle with `rx_data` = 0xA5 at E0+8+160, and `err` never high.
- **Parity error.** Send 0x3C with parity bit 1 (wrong for even). Require `err` pulse at the stop edge, `data_valid` = 0, and `rx_data` = 0x3C.
- **Framing error / break.** Send 0x55 with stop bit 0, then hold the line low for 40 cycles, then high. Require one `err` pulse and no `strt_sig` during the low hold. A following frame 0x12 is received correctly.
- **Glitch rejection.** Drive `rx_in` low for 4 cycles, then high. Require no `strt_sig`, no `err`, no `data_valid`, and the state back at IDLE.
- **Back-to-back frames.** Send frames 0x00 and 0xFF with no idle between them. Require two `data_valid` pulses 176 cycles apart with the correct data each time.
- **Reset mid-frame.** Assert `rst`=0 during data bit 3 of a frame. Require all outputs 0 and `rx_data`=0 after the edge, no pulses for the truncated frame, and the next full frame 0xC3 received correctly.
